// File: rtl/macc_feeder.sv
// macc_feeder -- serial-to-parallel operand packer for a multiply-accumulate array.
//
// Collects a stream of signed byte pairs (A, B) into NUM_INPUTS lanes. When the
// last lane is filled, it issues both packed vectors to the MAC stage with a
// one-cycle valid pulse. The next vector starts assembling on the following
// cycle with no bubble.
//
// Optional feature (macro MACC_FEEDER_PAD_EN):
//   defined   : an i_last below the top lane issues the partial vector. The
//               unwritten lanes are zero and o_last is set.
//   undefined : an early i_last sets the sticky o_err flag. The vector keeps
//               filling normally.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   i_data_a, i_data_b  signed operand bytes from upstream
//   i_valid, i_last     pair valid; final pair of a job (qualified by i_valid)
//   o_ready             pair can be accepted (no backpressure; low only in reset)
//   o_data_a, o_data_b  packed vectors, lane k at bits [8k+7:8k]
//   o_valid, o_last     one-cycle issue pulse; job end marker
//   o_err               sticky protocol-error flag
module macc_feeder #(
  parameter int NUM_INPUTS = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [7:0]            i_data_a,
  input  logic signed [7:0]            i_data_b,
  input  logic                         i_valid,
  input  logic                         i_last,
  output logic                         o_ready,
  output logic        [8*NUM_INPUTS-1:0] o_data_a,
  output logic        [8*NUM_INPUTS-1:0] o_data_b,
  output logic                         o_valid,
  output logic                         o_last,
  output logic                         o_err
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] TOP_LANE = CNT_W'(NUM_INPUTS - 1);

  logic        [CNT_W-1:0]           cnt_p0;
  logic signed [DATA_W-1:0]          lane_a_p0 [NUM_INPUTS];
  logic signed [DATA_W-1:0]          lane_b_p0 [NUM_INPUTS];
  logic        [DATA_W*NUM_INPUTS-1:0] data_a_p1;
  logic        [DATA_W*NUM_INPUTS-1:0] data_b_p1;
  logic                              vld_p1;
  logic                              last_p1;
  logic                              err_q;

  logic                              accept;
  logic                              at_top;
  logic                              early_last;
  logic                              issue;
  logic        [DATA_W*NUM_INPUTS-1:0] vec_a;
  logic        [DATA_W*NUM_INPUTS-1:0] vec_b;

  // No stall path: the block takes a pair every cycle it is out of reset.
  assign o_ready    = rst_n;
  assign accept     = i_valid & o_ready;
  assign at_top     = (cnt_p0 == TOP_LANE);
  assign early_last = accept & i_last & ~at_top;

`ifdef MACC_FEEDER_PAD_EN
  assign issue = accept & (at_top | i_last);
`else
  assign issue = accept & at_top;
`endif

  // Issued vector = stored lanes with the incoming pair merged into its lane,
  // so the completing pair reaches the output without an extra cycle.
  always_comb begin
    vec_a = '0;
    vec_b = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (accept && (k == int'(cnt_p0))) begin
        vec_a[DATA_W*k +: DATA_W] = i_data_a;
        vec_b[DATA_W*k +: DATA_W] = i_data_b;
      end else begin
        vec_a[DATA_W*k +: DATA_W] = lane_a_p0[k];
        vec_b[DATA_W*k +: DATA_W] = lane_b_p0[k];
      end
    end
  end

  // ---- stage p0: lane counter and assembly lanes ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (accept) begin
      cnt_p0 <= issue ? '0 : cnt_p0 + CNT_W'(1);
    end
  end

  // Lanes are cleared on issue so a short (padded) vector reads zero above
  // its last written lane.
  always_ff @(posedge clk) begin
    if (!rst_n || issue) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        lane_a_p0[k] <= '0;
        lane_b_p0[k] <= '0;
      end
    end else if (accept) begin
      lane_a_p0[cnt_p0] <= i_data_a;
      lane_b_p0[cnt_p0] <= i_data_b;
    end
  end

  // ---- stage p1: issued vector, valid pulse, job marker, error flag ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue & i_last;
`ifndef MACC_FEEDER_PAD_EN
      if (early_last) err_q <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
    end else if (issue) begin
      data_a_p1 <= vec_a;
      data_b_p1 <= vec_b;
    end
  end

`ifdef MACC_FEEDER_PAD_EN
  // Early i_last is legal here and is absorbed by the issue path.
  logic unused_early_last;
  assign unused_early_last = early_last;
`endif

  assign o_data_a = data_a_p1;
  assign o_data_b = data_b_p1;
  assign o_valid  = vld_p1;
  assign o_last   = last_p1;
  assign o_err    = err_q;

endmodule

// File: doc/macc_feeder.md
MACC_FEEDER -- requirements
Module: macc_feeder

Interface
- REQ-001 SHALL have parameter NUM_INPUTS, default 20, giving the number of 8-bit lanes per issued operand vector (legal range 2..64).
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: reset; synchronous and active-low.
- REQ-004 SHALL have port i_data_a, input, 8 bits: signed operand A byte, upstream stream.
- REQ-005 SHALL have port i_data_b, input, 8 bits: signed operand B byte, paired with i_data_a.
- REQ-006 SHALL have port i_valid, input, 1 bit: upstream pair valid.
- REQ-007 SHALL have port i_last, input, 1 bit: marks the final pair of a job; qualified by i_valid.
- REQ-008 SHALL have port o_ready, output, 1 bit: block can accept a pair this cycle.
- REQ-009 SHALL have port o_data_a, output, 8*NUM_INPUTS bits: packed operand A vector, lane k at bits [8k+7:8k].
- REQ-010 SHALL have port o_data_b, output, 8*NUM_INPUTS bits: packed operand B vector, same lane layout.
- REQ-011 SHALL have port o_valid, output, 1 bit: one-cycle pulse, vector valid for the multiply-accumulate stage.
- REQ-012 SHALL have port o_last, output, 1 bit: asserted with o_valid on the final vector of a job.
- REQ-013 SHALL have port o_err, output, 1 bit: sticky protocol-error flag.

Function
- REQ-014 A pair SHALL be accepted on a cycle when i_valid and o_ready are both 1.
- REQ-015 o_ready SHALL be 1 in every cycle after reset release; downstream has no backpressure, so there is no stall path.
- REQ-016 A lane counter, width $clog2(NUM_INPUTS), SHALL write each accepted pair into lane[count] and increment, counting 0..NUM_INPUTS-1.
- REQ-017 The first pair after reset or after an issue SHALL land in lane 0.
- REQ-018 On acceptance into lane NUM_INPUTS-1, the assembly lanes SHALL be copied into the output registers, and o_valid SHALL be 1 on the following cycle only, giving a latency of 1 cycle from the final accepted pair.
- REQ-019 On the cycle of that acceptance, the counter SHALL wrap to 0 and the next pair SHALL be accepted in the immediately following cycle with no bubble.
- REQ-020 o_data_a and o_data_b SHALL hold their last issued value until the next issue; they SHALL NOT change while o_valid is 0.
- REQ-021 o_last SHALL equal the i_last value captured with the pair that completed the issued vector, and SHALL be 0 whenever o_valid is 0.
- REQ-022 Bytes SHALL pass bit-exact with no sign extension or arithmetic.
- REQ-023 Lanes not written in the current vector SHALL read as zero in the issued vector.
- REQ-024 Assembly lanes SHALL be cleared on every issue.

Reset
- REQ-025 While rst_n is 0 at a clk edge, the following SHALL be set: counter 0, assembly lanes 0, o_data_a 0, o_data_b 0, o_valid 0, o_last 0, o_err 0.
- REQ-026 o_ready SHALL be 0 while rst_n is 0.
- REQ-027 A reset asserted mid-vector SHALL discard the partial vector and SHALL NOT issue it.
- REQ-028 A reset asserted in the cycle of an o_valid pulse SHALL force o_valid to 0 on the next cycle.

Configuration
- REQ-029 When macro MACC_FEEDER_PAD_EN is defined, i_last accepted in a lane below NUM_INPUTS-1 SHALL issue the partial vector with remaining lanes zero and o_last=1 on the next cycle, SHALL reset the counter to 0, and SHALL leave o_err unchanged.
- REQ-030 When MACC_FEEDER_PAD_EN is not defined, i_last accepted in a lane below NUM_INPUTS-1 SHALL set o_err to 1 until reset; the pair SHALL be stored normally and no issue SHALL occur until the counter wraps.

Verification
- REQ-031 NUM_INPUTS=4; feed pairs (1,-1),(2,-2),(3,-3),(4,-4) on consecutive cycles -> one cycle after the 4th, o_valid=1 for 1 cycle, o_data_a=32'h04030201, o_data_b=32'hFCFDFEFF, o_last=0.
- REQ-032 NUM_INPUTS=4; 8 back-to-back pairs with i_last on the 8th -> two o_valid pulses 4 cycles apart, o_ready constantly 1, second pulse has o_last=1.
- REQ-033 NUM_INPUTS=4; i_valid gapped every other cycle -> vectors identical to the gap-free case, o_valid only after every 4th accepted pair.
- REQ-034 NUM_INPUTS=4, MACC_FEEDER_PAD_EN defined; 2 pairs (5,6),(7,8) with i_last on the 2nd -> o_data_a=32'h00000705, o_data_b=32'h00000806, o_last=1, o_err=0; next pair lands in lane 0.
- REQ-035 NUM_INPUTS=4, macro not defined; same stimulus as REQ-034 -> no o_valid, o_err=1 and sticky; 2 more pairs -> issue with o_last=0.
- REQ-036 Assert rst_n=0 for 1 cycle after 3 of 4 pairs -> no issue; the next 4 pairs produce exactly one vector containing only the new data.
